// File: rtl/dec_pkg.sv
// Shared decode helpers for the select/strobe decoder.
//   SEL_W          : width of the select index {A,B}
//   OUT_W          : number of decoded strobe lines (2**SEL_W)
//   onehot_decode  : active-high one-hot decode of sel, gated by en
package dec_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OUT_W = 1 << SEL_W;

  // A shift plus a ternary lets X/Z on sel or en reach the result in
  // simulation instead of being masked by a failed compare.
  function automatic logic [OUT_W-1:0] onehot_decode(input logic [SEL_W-1:0] sel,
                                                     input logic             en);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return en ? (one << sel) : '0;
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 line decoder used as a generic select/strobe generator.
// Ports:
//   clk  : system clock, rising edge (registered mode only)
//   rst  : synchronous active-high reset (registered mode only)
//   EN   : decode enable; 0 drives every output to its inactive level
//   A, B : select index {A,B}, A is the MSB
//   Y0-3 : one-hot strobes, Yn asserted iff {A,B}==n and EN==1
// Parameters:
//   ACTIVE_LOW   : 1 = asserted output is 0, inactive outputs are 1
//   REGISTER_OUT : 1 = one-cycle registered output, 0 = pure combinational
module decoder_2to4
  import dec_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic EN,
  input  logic A,
  input  logic B,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3
);

  logic [OUT_W-1:0] dec_d;
  logic [OUT_W-1:0] dec_raw;
  logic [OUT_W-1:0] y_out;

  always_comb begin
    dec_d = onehot_decode({A, B}, EN);
  end

  generate
    if (REGISTER_OUT) begin : g_reg
      logic [OUT_W-1:0] dec_q;

      // The register holds the active-high decode, so reset to all-zero
      // lands on the inactive level for either polarity.
      always_ff @(posedge clk) begin
        if (rst) begin
          dec_q <= '0;
        end else begin
          dec_q <= dec_d;
        end
      end

      assign dec_raw = dec_q;
    end else begin : g_comb
      assign dec_raw = dec_d;
    end
  endgenerate

  // Polarity is applied after the register stage.
  assign y_out = dec_raw ^ {OUT_W{ACTIVE_LOW}};

  assign Y0 = y_out[0];
  assign Y1 = y_out[1];
  assign Y2 = y_out[2];
  assign Y3 = y_out[3];

endmodule

// File: tb/tb_decoder_2to4.sv
module tb_decoder_2to4;

  logic clk;
  logic rst, en, a, b;
  logic c_rst, c_en, c_a, c_b;
  logic [3:0] yh, yl, yc;

  int checks = 0;
  int errors = 0;

  // Registered, active-high
  decoder_2to4 #(.ACTIVE_LOW(1'b0), .REGISTER_OUT(1'b1)) u_hi (
    .clk(clk), .rst(rst), .EN(en), .A(a), .B(b),
    .Y0(yh[0]), .Y1(yh[1]), .Y2(yh[2]), .Y3(yh[3])
  );

  // Registered, active-low
  decoder_2to4 #(.ACTIVE_LOW(1'b1), .REGISTER_OUT(1'b1)) u_lo (
    .clk(clk), .rst(rst), .EN(en), .A(a), .B(b),
    .Y0(yl[0]), .Y1(yl[1]), .Y2(yl[2]), .Y3(yl[3])
  );

  // Combinational, active-high
  decoder_2to4 #(.ACTIVE_LOW(1'b0), .REGISTER_OUT(1'b0)) u_comb (
    .clk(clk), .rst(c_rst), .EN(c_en), .A(c_a), .B(c_b),
    .Y0(yc[0]), .Y1(yc[1]), .Y2(yc[2]), .Y3(yc[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       a;
    logic       b;
    logic [3:0] exp;   // Y3..Y0 of the active-high instance after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic ia,
                              input logic ib, input logic [3:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.a = ia; v.b = ib; v.exp = x;
    return v;
  endfunction

  // Reference: strobe number 2*A+B is the one raised, computed arithmetically.
  function automatic logic [3:0] ref_decode(input logic r, input logic e,
                                            input logic ia, input logic ib);
    int idx;
    if (r || !e) return 4'd0;
    idx = 2 * int'(ia) + int'(ib);
    return 4'(2 ** idx);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_onehot(input string name, input logic [3:0] got, input int exp_cnt);
    checks++;
    if ($countones(got) != exp_cnt || $isunknown(got)) begin
      errors++;
      $display("FAIL %s got %b expected %0d asserted at %0t", name, got, exp_cnt, $time);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic ia, input logic ib);
    rst = r; en = e; a = ia; b = ib;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp;
    logic r, e, ia, ib;

    rst = 1'b1; en = 1'b1; a = 1'b1; b = 1'b1;
    c_rst = 1'b1; c_en = 1'b1; c_a = 1'b0; c_b = 1'b0;

    // Reset with all inputs active, release, full sweep, enable gating, mid-run reset.
    vecs.push_back(mk(1, 1, 1, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1000));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 1, 0, 1, 4'b0010));
    vecs.push_back(mk(0, 1, 0, 1, 4'b0010));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1000));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1000));
    vecs.push_back(mk(0, 0, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 1, 0, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 0, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 1, 4'b0010));
    // Back-to-back select changes: each shows on the very next edge.
    vecs.push_back(mk(0, 1, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1000));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0000));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_hi", i), yh, vecs[i].exp);
      check($sformatf("vec%0d_lo", i), yl, vecs[i].exp ^ 4'b1111);
    end

    // Latency: an input change must not show before the edge.
    step(0, 1, 0, 0);
    a = 1'b1; b = 1'b1;
    #2;
    check("latency_hold_hi", yh, 4'b0001);
    @(posedge clk); #1;
    check("latency_load_hi", yh, 4'b1000);
    check("latency_load_lo", yl, 4'b0111);

    // Randomized run against the arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      r  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 4) != 0);
      ia = 1'($urandom);
      ib = 1'($urandom);
      exp = ref_decode(r, e, ia, ib);
      step(r, e, ia, ib);
      check($sformatf("rand%0d_hi", n), yh, exp);
      check($sformatf("rand%0d_lo", n), yl, exp ^ 4'b1111);
      check_onehot($sformatf("rand%0d_onehot", n), yh, (r || !e) ? 0 : 1);
    end

    // Combinational instance: rst held high and clock running must not matter.
    for (int s = 0; s < 4; s++) begin
      c_en = 1'b1;
      c_a = 1'(s >> 1);
      c_b = 1'(s & 1);
      #1;
      check($sformatf("comb_sel%0d_immediate", s), yc, ref_decode(0, 1, c_a, c_b));
      check_onehot($sformatf("comb_sel%0d_onehot", s), yc, 1);
      #19;
      check($sformatf("comb_sel%0d_held", s), yc, ref_decode(0, 1, c_a, c_b));
    end
    c_en = 1'b0;
    #1;
    check("comb_en0", yc, 4'b0000);
    c_rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      c_rst = 1'($urandom);
      c_en  = 1'($urandom);
      c_a   = 1'($urandom);
      c_b   = 1'($urandom);
      #3;
      check($sformatf("comb_rand%0d", n), yc, ref_decode(0, c_en, c_a, c_b));
      check_onehot($sformatf("comb_rand%0d_onehot", n), yc, c_en ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
